// File: rtl/serial_frame_deserializer.sv
// serial_frame_deserializer
//   Receive-side front end for the serial ALU link. Collects one frame of
//   serial packets (enable_n low for the whole frame) and presents operands,
//   opcode, operand count and error flags as one registered result with a
//   valid/ready handshake. The output register holds a single entry; a frame
//   that ends while that entry is still waiting is dropped and counted.
//
//   Packet, first bit first: start(0) kind(0=data,1=cmd) payload MSB..LSB.
//
// Ports
//   clk          clock, all sampling on posedge
//   reset        synchronous active-high reset
//   enable_n     frame enable, active low
//   din          serial data, sampled only while enable_n=0
//   ready_in     downstream accepts result when out_valid=1
//   out_valid    result available
//   out_ops      operand k at [k*DATA_W +: DATA_W], unused slots 0
//   out_op       command payload
//   out_count    number of operands stored
//   out_err      [0] START [1] ORDER [2] OVF [3] LEN [4] FEW
//   overrun_cnt  saturating count of dropped results
//   busy         high while receiving a frame
module serial_frame_deserializer #(
    parameter int DATA_W  = 8,
    parameter int MAX_OPS = 4,
    parameter int MIN_OPS = 2,
    parameter int CNT_W   = $clog2(MAX_OPS + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable_n,
    input  logic                      din,
    input  logic                      ready_in,
    output logic                      out_valid,
    output logic [MAX_OPS*DATA_W-1:0] out_ops,
    output logic [DATA_W-1:0]         out_op,
    output logic [CNT_W-1:0]          out_count,
    output logic [4:0]                out_err,
    output logic [7:0]                overrun_cnt,
    output logic                      busy
);
    localparam int PKT_W = DATA_W + 2;
    localparam int BC_W  = $clog2(PKT_W);

    typedef enum logic [1:0] {S_SYNC, S_IDLE, S_RECV} state_t;

    state_t                          r_state, w_next;
    logic [BC_W-1:0]                 r_bit_cnt;
    logic [PKT_W-2:0]                r_shift;
    logic [CNT_W-1:0]                r_op_cnt;
    logic                            r_cmd_seen;
    logic [2:0]                      r_err;      // START, ORDER, OVF
    logic [MAX_OPS-1:0][DATA_W-1:0]  r_slots;
    logic [DATA_W-1:0]               r_opcode;

    // Full packet as it stands on the edge sampling its last bit.
    logic [PKT_W-1:0]  w_pkt;
    logic              w_pkt_done;
    logic              w_frame_end;
    logic              w_load;
    logic              w_len;
    logic              w_few;

    assign w_pkt       = {r_shift, din};
    assign w_pkt_done  = (r_state == S_RECV) && !enable_n &&
                         (r_bit_cnt == BC_W'(PKT_W - 1));
    assign w_frame_end = (r_state == S_RECV) && enable_n;
    // A held result blocks the new one unless it is being taken this edge.
    assign w_load      = w_frame_end && (!out_valid || ready_in);
    assign w_len       = (r_bit_cnt != '0) || !r_cmd_seen;
    assign w_few       = r_op_cnt < CNT_W'(MIN_OPS);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_SYNC;
        else       r_state <= w_next;
    end

    // FSM: next state. SYNC waits for an idle line so a frame already in
    // flight at reset is never partially decoded.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_SYNC:  if (enable_n)  w_next = S_IDLE;
            S_IDLE:  if (!enable_n) w_next = S_RECV;
            S_RECV:  if (enable_n)  w_next = S_IDLE;
            default: w_next = S_SYNC;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (r_state == S_RECV);
    end

    // Per-frame receive datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_op_cnt   <= '0;
            r_cmd_seen <= 1'b0;
            r_err      <= '0;
            r_slots    <= '0;
            r_opcode   <= '0;
        end else if (r_state == S_IDLE && !enable_n) begin
            // First edge of a frame samples bit0 and wipes the frame state.
            r_shift    <= {r_shift[PKT_W-3:0], din};
            r_bit_cnt  <= BC_W'(1);
            r_op_cnt   <= '0;
            r_cmd_seen <= 1'b0;
            r_err      <= '0;
            r_slots    <= '0;
            r_opcode   <= '0;
        end else if (r_state == S_RECV && !enable_n) begin
            r_shift   <= {r_shift[PKT_W-3:0], din};
            r_bit_cnt <= w_pkt_done ? '0 : r_bit_cnt + BC_W'(1);
            if (w_pkt_done) begin
                if (w_pkt[PKT_W-1]) begin
                    r_err[0] <= 1'b1;
                end else if (!w_pkt[PKT_W-2]) begin
                    if (r_cmd_seen) begin
                        r_err[1] <= 1'b1;
                    end else if (r_op_cnt == CNT_W'(MAX_OPS)) begin
                        r_err[2] <= 1'b1;
                    end else begin
                        for (int k = 0; k < MAX_OPS; k++)
                            if (r_op_cnt == CNT_W'(k))
                                r_slots[k] <= w_pkt[DATA_W-1:0];
                        r_op_cnt <= r_op_cnt + CNT_W'(1);
                    end
                end else begin
                    if (r_cmd_seen) begin
                        r_err[1] <= 1'b1;
                    end else begin
                        r_opcode   <= w_pkt[DATA_W-1:0];
                        r_cmd_seen <= 1'b1;
                    end
                end
            end
        end
    end

    // Single-entry output register with overrun accounting
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_ops     <= '0;
            out_op      <= '0;
            out_count   <= '0;
            out_err     <= '0;
            overrun_cnt <= '0;
        end else if (w_load) begin
            out_valid <= 1'b1;
            out_ops   <= r_slots;
            out_op    <= r_opcode;
            out_count <= r_op_cnt;
            out_err   <= {w_few, w_len, r_err};
        end else begin
            if (out_valid && ready_in)
                out_valid <= 1'b0;
            // Frame ended with no room: result lost.
            if (w_frame_end && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
endmodule
